// File: rtl/div_unit_pkg.sv
// div_unit_pkg: op_type and FSM state encodings shared by the divider and its users
package div_unit_pkg;
   localparam logic [1:0] DIV_S = 2'b00;
   localparam logic [1:0] DIVU  = 2'b01;
   localparam logic [1:0] REM_S = 2'b10;
   localparam logic [1:0] REMU  = 2'b11;
   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: start/busy/done request bundle between the EX stage and the divider
interface div_unit_if;
   logic        start;
   logic        kill;
   logic [31:0] a_div;
   logic [31:0] b_div;
   logic [1:0]  op_type;
   logic        busy;
   logic        done;
   logic [31:0] div_result;
   modport master (output start, kill, a_div, b_div, op_type, input busy, done, div_result);
   modport slave  (input start, kill, a_div, b_div, op_type, output busy, done, div_result);
endinterface

// File: rtl/div_unit_step.sv
// div_step: one restoring radix-2 iteration on a 33-bit partial remainder
module div_step (
   input  logic [31:0] rem_in,
   input  logic        bit_in,
   input  logic [31:0] dvs,
   output logic [31:0] rem_out,
   output logic        q_bit
);
   logic [32:0] part, diff;
   assign part    = {rem_in, bit_in};
   assign diff    = part - {1'b0, dvs};
   assign q_bit   = !diff[32];
   assign rem_out = q_bit ? diff[31:0] : part[31:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU with start/busy/done handshake and kill
module div_unit
   import div_unit_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   div_unit_if.slave bus
);
   state_t      state, state_nx;
   logic [4:0]  cnt;
   logic [31:0] dvd, rem, dvs, step_rem, a_abs, b_abs, quot_fix, rem_fix;
   logic        quot_neg, rem_neg, rem_sel, step_q, sgn, zero, ovf, special, accept;
   assign sgn      = !bus.op_type[0];
   assign a_abs    = (sgn && bus.a_div[31]) ? -bus.a_div : bus.a_div;
   assign b_abs    = (sgn && bus.b_div[31]) ? -bus.b_div : bus.b_div;
   assign zero     = bus.b_div == 32'h0;
   assign ovf      = sgn && bus.a_div == 32'h8000_0000 && bus.b_div == 32'hFFFF_FFFF;
   assign special  = zero || ovf;
   assign accept   = state == IDLE && bus.start && !bus.kill;
   assign quot_fix = quot_neg ? -dvd : dvd;
   assign rem_fix  = rem_neg ? -rem : rem;
   assign bus.busy = state != IDLE;
   div_step u_step (
      .rem_in (rem),
      .bit_in (dvd[31]),
      .dvs    (dvs),
      .rem_out(step_rem),
      .q_bit  (step_q)
   );
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   always_comb begin
      state_nx = bus.kill ? IDLE :
                 state == IDLE ? (accept ? (special ? FIN : CALC) : IDLE) :
                 state == CALC ? (cnt == 5'd31 ? FIN : CALC) : IDLE;
   end
   // special cases preload quotient/remainder so FIN fix-up is the same for every op
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt            <= '0;
         dvd            <= '0;
         rem            <= '0;
         dvs            <= '0;
         quot_neg       <= 1'b0;
         rem_neg        <= 1'b0;
         rem_sel        <= 1'b0;
         bus.done       <= 1'b0;
         bus.div_result <= '0;
      end else begin
         bus.done <= state == FIN && !bus.kill;
         if (state == FIN && !bus.kill) bus.div_result <= rem_sel ? rem_fix : quot_fix;
         if (accept) begin
            cnt      <= '0;
            rem_sel  <= bus.op_type[1];
            dvs      <= b_abs;
            dvd      <= zero ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : a_abs;
            rem      <= zero ? bus.a_div : 32'h0;
            quot_neg <= !special && sgn && (bus.a_div[31] ^ bus.b_div[31]);
            rem_neg  <= !special && sgn && bus.a_div[31];
         end else if (bus.kill) begin
            cnt <= '0;
         end else if (state == CALC) begin
            cnt <= cnt + 5'd1;
            rem <= step_rem;
            dvd <= {dvd[30:0], step_q};
         end
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors with a scoreboard queue checked by a done-driven monitor
module tb_div_unit;
   import div_unit_pkg::*;
   typedef struct {
      logic [31:0] res;
      int          due;
      int          run;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          run = 0;
   logic        prev_done = 1'b0;
   logic [31:0] last_exp = 32'h0;
   exp_t        sb[$];
   exp_t        mon_e;
   div_unit_if bus ();
   div_unit dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // monitor: every done must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (bus.done) begin
         chk("done_pulse", {31'h0, prev_done}, 32'h0);
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got result %h with no request pending (cycle %0d)", bus.div_result, cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("result", bus.div_result, mon_e.res);
            chk("done_cycle", cyc, mon_e.due);
            chk("busy_len", run, mon_e.run);
         end
         run = 0;
      end else begin
         run = bus.busy ? run + 1 : 0;
      end
      prev_done = bus.done;
   end
   task automatic go(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                     input logic [31:0] exp, input int lat);
      bus.start   = 1'b1;
      bus.a_div   = a;
      bus.b_div   = b;
      bus.op_type = op;
      sb.push_back('{exp, cyc + lat, lat - 1});
      last_exp = exp;
      @(negedge clk);
      bus.start = 1'b0;
   endtask
   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [31:0] exp, input int lat);
      go(a, b, op, exp, lat);
      drain();
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.start   = 1'b0;
      bus.kill    = 1'b0;
      bus.a_div   = '0;
      bus.b_div   = '0;
      bus.op_type = DIVU;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'h0, bus.busy}, 32'h0);
      chk("rst_done", {31'h0, bus.done}, 32'h0);
      chk("rst_result", bus.div_result, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      run_op(32'd100, 32'd7, DIVU, 32'd14, 34);
      run_op(32'd100, 32'd7, REMU, 32'd2, 34);
      run_op(32'hFFFF_FFF9, 32'd2, DIV_S, 32'hFFFF_FFFD, 34);
      run_op(32'hFFFF_FFF9, 32'd2, REM_S, 32'hFFFF_FFFF, 34);
      run_op(32'h1234_5678, 32'h0, DIV_S, 32'hFFFF_FFFF, 2);
      run_op(32'h1234_5678, 32'h0, DIVU, 32'hFFFF_FFFF, 2);
      run_op(32'h1234_5678, 32'h0, REM_S, 32'h1234_5678, 2);
      run_op(32'h1234_5678, 32'h0, REMU, 32'h1234_5678, 2);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, DIV_S, 32'h8000_0000, 2);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, REM_S, 32'h0, 2);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, DIVU, 32'h0, 34);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, REMU, 32'h8000_0000, 34);
      run_op(32'h8000_0000, 32'd1, DIV_S, 32'h8000_0000, 34);
      run_op(32'd20, 32'hFFFF_FFFD, DIV_S, 32'hFFFF_FFFA, 34);
      run_op(32'd20, 32'hFFFF_FFFD, REM_S, 32'd2, 34);
      run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, DIV_S, 32'd14, 34);
      run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, REM_S, 32'hFFFF_FFFE, 34);
      run_op(32'hFFFF_FFFF, 32'd10, REMU, 32'd5, 34);
      // start while busy must not disturb the running divide
      go(32'd100, 32'd7, DIVU, 32'd14, 34);
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      bus.a_div = 32'd9;
      bus.b_div = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      drain();
      // back-to-back: second start driven in the done cycle
      go(32'd1000, 32'd10, DIVU, 32'd100, 34);
      for (int i = 0; i < 60 && !bus.done; i++) @(negedge clk);
      go(32'd1000, 32'd7, REMU, 32'd6, 34);
      drain();
      // kill mid-divide, then restart the next cycle
      bus.start   = 1'b1;
      bus.a_div   = 32'd100;
      bus.b_div   = 32'd7;
      bus.op_type = DIVU;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      chk("kill_busy", {31'h0, bus.busy}, 32'h0);
      chk("kill_result_held", bus.div_result, last_exp);
      go(32'd50, 32'd5, DIVU, 32'd10, 34);
      drain();
      // kill during FIN of a special case
      bus.start = 1'b1;
      bus.a_div = 32'd77;
      bus.b_div = 32'd0;
      @(negedge clk);
      bus.start = 1'b0;
      bus.kill  = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      chk("kill_fin_done", {31'h0, bus.done}, 32'h0);
      chk("kill_fin_result", bus.div_result, last_exp);
      // kill and start together: request dropped
      bus.start = 1'b1;
      bus.kill  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      chk("kill_start_busy", {31'h0, bus.busy}, 32'h0);
      repeat (5) @(negedge clk);
      // reset mid-operation
      go(32'd100, 32'd7, DIVU, 32'd14, 34);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
      chk("midrst_done", {31'h0, bus.done}, 32'h0);
      chk("midrst_result", bus.div_result, 32'h0);
      run_op(32'd45, 32'd6, DIVU, 32'd7, 34);
      repeat (40) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
